// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives a request with operands; the slave returns status and the held result.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell plus a borrow flip-flop,
// producing diff = a - b (mod 2^WIDTH) and the final borrow after WIDTH cycles.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             bff;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             x;
    logic             y;
    logic             d;
    logic             bo;
    logic             last;

    // Full-subtractor cell working on the current LSBs and the stored borrow.
    assign x    = sa[0];
    assign y    = sb[0];
    assign d    = x ^ y ^ bff;
    assign bo   = (~x & y) | (~(x ^ y) & bff);
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured only on an accepted start; the result registers
    // move only on the completing edge so they hold the previous result during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa       <= '0;
            sb       <= '0;
            sr       <= '0;
            cnt      <= '0;
            bff      <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        bff <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sr  <= {d, sr[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    bff <= bo;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        diff_q   <= {d, sr[WIDTH-1:1]};
                        borrow_q <= bo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
endmodule
